// File: rtl/nn_pkg.sv
// ---------------------------------------------------------------------------
// nn_pkg -- shared definitions for the neural-network post-processing blocks.
//
// Contents:
//   argmax_state_t : argmax frame state (ACCUM collects beats, HOLD presents
//                    the result until the consumer takes it).
//   CMP_W          : working width used by the generic score compare.
//   idx_width()    : index width for a class count, never less than 1 bit.
//   score_beats()  : "a beats b" for scores already extended to CMP_W bits,
//                    with a signed-compare flag and a tie-goes-to-a flag.
// ---------------------------------------------------------------------------
package nn_pkg;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } argmax_state_t;

   // Scores up to 64 bits wide are supported by the generic compare.
   localparam int CMP_W = 64;

   // $clog2(1) is 0; a single-class frame still needs a 1-bit index port.
   function automatic int idx_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Callers sign-extend (signed_cmp=1) or zero-extend (signed_cmp=0) their
   // scores to CMP_W bits before calling, so one compare serves any DATA_W.
   function automatic logic score_beats(input logic [CMP_W-1:0] a,
                                        input logic [CMP_W-1:0] b,
                                        input logic             signed_cmp,
                                        input logic             tie_last);
      logic gt;
      if (signed_cmp) gt = ($signed(a) > $signed(b));
      else            gt = (a > b);
      return gt || (tie_last && (a == b));
   endfunction

endpackage

// File: rtl/stream_argmax_score_cmp.sv
// ---------------------------------------------------------------------------
// score_cmp -- combinational score comparator used by stream_argmax.
//
// Ports:
//   i_a     [DATA_W] : challenger score (the incoming beat)
//   i_b     [DATA_W] : incumbent score (current best or runner-up)
//   o_beats          : 1 when i_a should replace i_b, i.e. i_a > i_b, or
//                      i_a == i_b and TIE_LAST=1. SIGNED_CMP selects two's
//                      complement or unsigned ordering.
// ---------------------------------------------------------------------------
module score_cmp
   import nn_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int SIGNED_CMP = 0,
   parameter int TIE_LAST   = 1
) (
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   output logic              o_beats
);

   logic [CMP_W-1:0] w_a;
   logic [CMP_W-1:0] w_b;

   // NOTE: every signal written here gets a value on every path, otherwise
   // the tool infers a latch to hold the missing case.
   always_comb begin
      if (SIGNED_CMP != 0) begin
         w_a = CMP_W'($signed(i_a));
         w_b = CMP_W'($signed(i_b));
      end else begin
         w_a = CMP_W'(i_a);
         w_b = CMP_W'(i_b);
      end
      o_beats = score_beats(w_a, w_b, SIGNED_CMP != 0, TIE_LAST != 0);
   end

endmodule

// File: rtl/stream_argmax.sv
// ---------------------------------------------------------------------------
// stream_argmax -- streaming argmax over a frame of NUM_CLASSES scores.
//
// Scores arrive one class per beat (valid/ready). The frame closes on the
// beat carrying in_last or on beat NUM_CLASSES, whichever comes first; one
// cycle later the registered result is presented until out_ready. No new
// beat is accepted while a result is pending.
//
// Ports:
//   clk, rst         : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready: input handshake; in_data is the score, in_last ends
//                      the frame
//   out_valid/out_ready : result handshake
//   out_index        : winning class index
//   out_value        : winning score
//   out_count        : number of beats in the frame
//   out_err          : frame length disagreed with in_last
//
// Optional feature (macro ARGMAX_TOP2_EN): adds out_second_index,
// out_second_value, out_margin (best minus runner-up, 0 if none) and
// out_second_valid (frame had two or more beats).
// ---------------------------------------------------------------------------
module stream_argmax
   import nn_pkg::*;
#(
   parameter  int NUM_CLASSES = 10,
   parameter  int DATA_W      = 16,
   parameter  int SIGNED_CMP  = 0,
   parameter  int TIE_LAST    = 1,
   localparam int IDX_W       = idx_width(NUM_CLASSES)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IDX_W-1:0]  out_index,
   output logic [DATA_W-1:0] out_value,
   output logic [IDX_W:0]    out_count,
`ifdef ARGMAX_TOP2_EN
   output logic [IDX_W-1:0]  out_second_index,
   output logic [DATA_W-1:0] out_second_value,
   output logic [DATA_W:0]   out_margin,
   output logic              out_second_valid,
`endif
   output logic              out_err
);

   localparam int COUNT_W = IDX_W + 1;

   argmax_state_t       r_state;
   logic                r_in_ready;
   logic                r_out_valid;
   logic [DATA_W-1:0]   r_best_value;
   logic [IDX_W-1:0]    r_best_index;
   logic [COUNT_W-1:0]  r_count;
   logic [IDX_W-1:0]    r_out_index;
   logic [DATA_W-1:0]   r_out_value;
   logic [COUNT_W-1:0]  r_out_count;
   logic                r_out_err;

   logic                w_fire;
   logic                w_first;
   logic [IDX_W-1:0]    w_beat_index;
   logic [COUNT_W-1:0]  w_nxt_count;
   logic                w_at_limit;
   logic                w_close;
   logic                w_err;
   logic                w_beats_best;
   logic                w_take_best;
   logic [DATA_W-1:0]   w_nxt_best_value;
   logic [IDX_W-1:0]    w_nxt_best_index;

   score_cmp #(
      .DATA_W    (DATA_W),
      .SIGNED_CMP(SIGNED_CMP),
      .TIE_LAST  (TIE_LAST)
   ) u_cmp_best (
      .i_a    (in_data),
      .i_b    (r_best_value),
      .o_beats(w_beats_best)
   );

   always_comb begin
      w_fire       = in_valid && r_in_ready;
      w_first      = (r_count == '0);
      // Beats already counted equal the position of the current beat.
      w_beat_index = r_count[IDX_W-1:0];
      w_nxt_count  = r_count + 1'b1;
      w_at_limit   = (w_nxt_count == COUNT_W'(NUM_CLASSES));
      w_close      = in_last || w_at_limit;
      // Error when in_last and the class limit do not land on the same beat.
      w_err        = (in_last != w_at_limit);
      w_take_best  = w_first || w_beats_best;
      w_nxt_best_value = w_take_best ? in_data      : r_best_value;
      w_nxt_best_index = w_take_best ? w_beat_index : r_best_index;
   end

`ifdef ARGMAX_TOP2_EN
   logic [DATA_W-1:0] r_second_value;
   logic [IDX_W-1:0]  r_second_index;
   logic              r_second_valid;
   logic [IDX_W-1:0]  r_out_second_index;
   logic [DATA_W-1:0] r_out_second_value;
   logic [DATA_W:0]   r_out_margin;
   logic              r_out_second_valid;

   logic              w_beats_second;
   logic              w_take_second;
   logic [DATA_W-1:0] w_nxt_second_value;
   logic [IDX_W-1:0]  w_nxt_second_index;
   logic              w_nxt_second_valid;
   logic [DATA_W:0]   w_margin;

   score_cmp #(
      .DATA_W    (DATA_W),
      .SIGNED_CMP(SIGNED_CMP),
      .TIE_LAST  (TIE_LAST)
   ) u_cmp_second (
      .i_a    (in_data),
      .i_b    (r_second_value),
      .o_beats(w_beats_second)
   );

   always_comb begin
      // A displaced best drops to runner-up; otherwise the beat competes for
      // runner-up, and an empty runner-up slot takes any non-first beat.
      w_take_second      = !w_first && (w_beats_best || !r_second_valid || w_beats_second);
      w_nxt_second_value = r_second_value;
      w_nxt_second_index = r_second_index;
      if (w_take_second) begin
         w_nxt_second_value = w_beats_best ? r_best_value : in_data;
         w_nxt_second_index = w_beats_best ? r_best_index : w_beat_index;
      end
      w_nxt_second_valid = r_second_valid || w_take_second;
      // Best never ranks below runner-up, so the extended difference is >= 0.
      if (SIGNED_CMP != 0)
         w_margin = {w_nxt_best_value[DATA_W-1], w_nxt_best_value}
                  - {w_nxt_second_value[DATA_W-1], w_nxt_second_value};
      else
         w_margin = {1'b0, w_nxt_best_value} - {1'b0, w_nxt_second_value};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_second_value     <= '0;
         r_second_index     <= '0;
         r_second_valid     <= 1'b0;
         r_out_second_index <= '0;
         r_out_second_value <= '0;
         r_out_margin       <= '0;
         r_out_second_valid <= 1'b0;
      end else if (r_state == ACCUM) begin
         if (w_fire) begin
            r_second_value <= w_nxt_second_value;
            r_second_index <= w_nxt_second_index;
            r_second_valid <= w_nxt_second_valid;
            if (w_close) begin
               r_out_second_index <= w_nxt_second_index;
               r_out_second_value <= w_nxt_second_value;
               r_out_second_valid <= w_nxt_second_valid;
               r_out_margin       <= w_nxt_second_valid ? w_margin : '0;
            end
         end
      end else if (out_ready) begin
         r_second_value <= '0;
         r_second_index <= '0;
         r_second_valid <= 1'b0;
      end
   end

   assign out_second_index = r_out_second_index;
   assign out_second_value = r_out_second_value;
   assign out_margin       = r_out_margin;
   assign out_second_valid = r_out_second_valid;
`endif

   // NOTE: non-blocking assignments make every register here sample the
   // pre-edge values, so the order of statements does not matter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ACCUM;
         r_in_ready   <= 1'b1;
         r_out_valid  <= 1'b0;
         r_best_value <= '0;
         r_best_index <= '0;
         r_count      <= '0;
         r_out_index  <= '0;
         r_out_value  <= '0;
         r_out_count  <= '0;
         r_out_err    <= 1'b0;
      end else begin
         case (r_state)
            ACCUM: begin
               if (w_fire) begin
                  r_best_value <= w_nxt_best_value;
                  r_best_index <= w_nxt_best_index;
                  r_count      <= w_nxt_count;
                  if (w_close) begin
                     r_state     <= HOLD;
                     r_in_ready  <= 1'b0;
                     r_out_valid <= 1'b1;
                     r_out_index <= w_nxt_best_index;
                     r_out_value <= w_nxt_best_value;
                     r_out_count <= w_nxt_count;
                     r_out_err   <= w_err;
                  end
               end
            end
            HOLD: begin
               // Result outputs keep their values after the handshake.
               if (out_ready) begin
                  r_state      <= ACCUM;
                  r_in_ready   <= 1'b1;
                  r_out_valid  <= 1'b0;
                  r_best_value <= '0;
                  r_best_index <= '0;
                  r_count      <= '0;
               end
            end
            default: r_state <= ACCUM;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_index = r_out_index;
   assign out_value = r_out_value;
   assign out_count = r_out_count;
   assign out_err   = r_out_err;

endmodule

// File: tb/tb_stream_argmax.sv
// ---------------------------------------------------------------------------
// tb_stream_argmax -- self-checking bench for stream_argmax.
//
// Three 10-class instances share one input stream: k=0 unsigned/tie-last,
// k=1 signed/tie-last, k=2 unsigned/tie-first. A fourth instance has
// NUM_CLASSES=1 with its own stream. Expected results come from a
// reference model that ranks the whole frame at once.
// Honours ARGMAX_TOP2_EN to also check the runner-up outputs.
// ---------------------------------------------------------------------------
module tb_stream_argmax;

   localparam int N  = 10;
   localparam int DW = 16;
   localparam int IW = 4;

   typedef struct {
      int index;
      int value;
      int count;
      bit err;
      bit sec_valid;
      int sec_index;
      int sec_value;
      int margin;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_last = 1'b0;
   logic          out_ready = 1'b0;
   logic [DW-1:0] in_data = '0;

   logic          rdy_o [3];
   logic          vld_o [3];
   logic          err_o [3];
   logic [IW-1:0] idx_o [3];
   logic [DW-1:0] val_o [3];
   logic [IW:0]   cnt_o [3];
`ifdef ARGMAX_TOP2_EN
   logic [IW-1:0] sidx_o [3];
   logic [DW-1:0] sval_o [3];
   logic [DW:0]   mar_o  [3];
   logic          sv_o   [3];
`endif

   bit sgn_cfg [3] = '{1'b0, 1'b1, 1'b0};
   bit tie_cfg [3] = '{1'b1, 1'b1, 1'b0};

   for (genvar k = 0; k < 3; k++) begin : g_dut
      stream_argmax #(
         .NUM_CLASSES(N),
         .DATA_W     (DW),
         .SIGNED_CMP (k == 1 ? 1 : 0),
         .TIE_LAST   (k == 2 ? 0 : 1)
      ) u_dut (
         .clk      (clk),
         .rst      (rst),
         .in_valid (in_valid),
         .in_ready (rdy_o[k]),
         .in_data  (in_data),
         .in_last  (in_last),
         .out_valid(vld_o[k]),
         .out_ready(out_ready),
         .out_index(idx_o[k]),
         .out_value(val_o[k]),
         .out_count(cnt_o[k]),
`ifdef ARGMAX_TOP2_EN
         .out_second_index(sidx_o[k]),
         .out_second_value(sval_o[k]),
         .out_margin      (mar_o[k]),
         .out_second_valid(sv_o[k]),
`endif
         .out_err  (err_o[k])
      );
   end

   logic          o1_in_valid = 1'b0;
   logic          o1_in_last = 1'b0;
   logic          o1_out_ready = 1'b0;
   logic [DW-1:0] o1_in_data = '0;
   logic          o1_rdy, o1_vld, o1_err;
   logic [0:0]    o1_idx;
   logic [DW-1:0] o1_val;
   logic [1:0]    o1_cnt;
`ifdef ARGMAX_TOP2_EN
   logic [0:0]    o1_sidx;
   logic [DW-1:0] o1_sval;
   logic [DW:0]   o1_mar;
   logic          o1_sv;
`endif

   stream_argmax #(.NUM_CLASSES(1), .DATA_W(DW)) u_one (
      .clk      (clk),
      .rst      (rst),
      .in_valid (o1_in_valid),
      .in_ready (o1_rdy),
      .in_data  (o1_in_data),
      .in_last  (o1_in_last),
      .out_valid(o1_vld),
      .out_ready(o1_out_ready),
      .out_index(o1_idx),
      .out_value(o1_val),
      .out_count(o1_cnt),
`ifdef ARGMAX_TOP2_EN
      .out_second_index(o1_sidx),
      .out_second_value(o1_sval),
      .out_margin      (o1_mar),
      .out_second_valid(o1_sv),
`endif
      .out_err  (o1_err)
   );

   int errors = 0;
   int checks = 0;

   // ---------------- reference model ----------------
   function automatic int key(input int v, input bit sgn);
      if (sgn && v >= 32768) return v - 65536;
      return v;
   endfunction

   // Ranks a whole frame: find the top key, then pick its first or last
   // occurrence; the runner-up is the same search with the winner removed.
   function automatic exp_t model(input int sc[$], input int last_pos,
                                  input int n, input bit sgn, input bit tie);
      exp_t e;
      int   mx, smx, base;
      bit   found;
      e = '{default: 0};
      e.count = (last_pos >= 1 && last_pos < n) ? last_pos : n;
      e.err   = (last_pos != n);
      mx = key(sc[0], sgn);
      for (int i = 1; i < e.count; i++) if (key(sc[i], sgn) > mx) mx = key(sc[i], sgn);
      found = 1'b0;
      for (int i = 0; i < e.count; i++)
         if (key(sc[i], sgn) == mx && (tie || !found)) begin e.index = i; found = 1'b1; end
      e.value = sc[e.index];
      if (e.count >= 2) begin
         e.sec_valid = 1'b1;
         base = (e.index == 0) ? 1 : 0;
         smx = key(sc[base], sgn);
         for (int i = 0; i < e.count; i++)
            if (i != e.index && key(sc[i], sgn) > smx) smx = key(sc[i], sgn);
         found = 1'b0;
         for (int i = 0; i < e.count; i++)
            if (i != e.index && key(sc[i], sgn) == smx && (tie || !found)) begin
               e.sec_index = i; found = 1'b1;
            end
         e.sec_value = sc[e.sec_index];
         e.margin    = mx - smx;
      end
      return e;
   endfunction

   // ---------------- stimulus helpers (called at a negedge) ----------------
   task automatic send_frame(input int sc[$], input int count, input int last_pos,
                             input int gmax);
      for (int i = 0; i < count; i++) begin
         int g, guard;
         g = $urandom_range(0, gmax);
         if (g > 0) begin
            in_valid = 1'b0; in_last = 1'b0;
            repeat (g) @(negedge clk);
         end
         guard = 0;
         while (rdy_o[0] !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
         if (guard >= 100) begin
            errors++; checks++;
            $display("FAIL in_ready_timeout: got %b want 1", rdy_o[0]);
         end
         in_valid = 1'b1;
         in_data  = DW'(sc[i]);
         in_last  = (i + 1 == last_pos);
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic ack();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; in_data = 16'h7777; in_last = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ({rdy_o[k], vld_o[k], idx_o[k], val_o[k], cnt_o[k], err_o[k]} !== {1'b1, 1'b0, 26'd0}) begin
            errors++;
            $display("FAIL reset_state k=%0d: got rdy=%b vld=%b idx=%0d val=%0d cnt=%0d err=%b want rdy=1 rest 0",
                     k, rdy_o[k], vld_o[k], idx_o[k], val_o[k], cnt_o[k], err_o[k]);
         end
      end
   endtask

   task automatic test_ref_frame();
      int sc[$] = '{3, 9, 1, 9, 0, 2, 2, 8, 7, 5};
      int want_idx [3] = '{3, 3, 1};
      send_frame(sc, 10, 10, 1);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ({vld_o[k], idx_o[k], val_o[k], cnt_o[k], err_o[k]} !==
             {1'b1, want_idx[k][IW-1:0], 16'd9, 5'd10, 1'b0}) begin
            errors++;
            $display("FAIL ref_frame k=%0d: got vld=%b idx=%0d val=%0d cnt=%0d err=%b want vld=1 idx=%0d val=9 cnt=10 err=0",
                     k, vld_o[k], idx_o[k], val_o[k], cnt_o[k], err_o[k], want_idx[k]);
         end
      end
      ack();
   endtask

   task automatic test_signed();
      int sc[$] = '{32'hFFFF, 32'h8000, 0, 0, 0, 0, 0, 0, 0, 0};
      int want_idx [3] = '{0, 9, 0};
      int want_val [3] = '{32'hFFFF, 0, 32'hFFFF};
      send_frame(sc, 10, 10, 0);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (idx_o[k] !== want_idx[k][IW-1:0] || val_o[k] !== want_val[k][DW-1:0]) begin
            errors++;
            $display("FAIL signed_frame k=%0d: got idx=%0d val=%h want idx=%0d val=%h",
                     k, idx_o[k], val_o[k], want_idx[k], want_val[k][DW-1:0]);
         end
      end
      ack();
   endtask

   task automatic test_short_frame();
      int head[$] = '{5, 6, 7};
      int tail[$] = '{1};
      int full[$];
      send_frame(head, 3, 0, 1);
      checks++;
      if (vld_o[0] !== 1'b0) begin
         errors++; $display("FAIL short_early_valid: got %b want 0", vld_o[0]);
      end
      send_frame(tail, 1, 1, 0);
      checks++;
      if ({vld_o[0], idx_o[0], cnt_o[0], err_o[0]} !== {1'b1, 4'd2, 5'd4, 1'b1}) begin
         errors++;
         $display("FAIL short_last: got vld=%b idx=%0d cnt=%0d err=%b want vld=1 idx=2 cnt=4 err=1",
                  vld_o[0], idx_o[0], cnt_o[0], err_o[0]);
      end
      ack();
      for (int i = 0; i < N; i++) full.push_back($urandom_range(0, 65535));
      send_frame(full, N, 0, 1);
      checks++;
      if ({vld_o[0], cnt_o[0], err_o[0]} !== {1'b1, 5'd10, 1'b1}) begin
         errors++;
         $display("FAIL missing_last: got vld=%b cnt=%0d err=%b want vld=1 cnt=10 err=1",
                  vld_o[0], cnt_o[0], err_o[0]);
      end
      ack();
   endtask

   task automatic test_hold();
      int sc[$] = '{3, 9, 1, 9, 0, 2, 2, 8, 7, 5};
      int nx[$];
      exp_t e;
      int bad = 0;
      send_frame(sc, 10, 10, 0);
      for (int c = 0; c < 20; c++) begin
         in_valid = 1'b1; in_data = DW'($urandom); in_last = 1'($urandom);
         @(negedge clk);
         if ({rdy_o[0], vld_o[0], idx_o[0], val_o[0], cnt_o[0], err_o[0]} !==
             {1'b0, 1'b1, 4'd3, 16'd9, 5'd10, 1'b0}) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL hold_stable: got %0d unstable cycles want 0", bad);
      end
      in_valid = 1'b0; in_last = 1'b0;
      ack();
      checks++;
      if ({rdy_o[0], vld_o[0]} !== 2'b10) begin
         errors++; $display("FAIL hold_release: got rdy=%b vld=%b want rdy=1 vld=0", rdy_o[0], vld_o[0]);
      end
      for (int i = 0; i < N; i++) nx.push_back($urandom_range(0, 20));
      e = model(nx, 7, N, 1'b0, 1'b1);
      send_frame(nx, e.count, 7, 0);
      checks++;
      if (idx_o[0] !== e.index[IW-1:0] || cnt_o[0] !== e.count[IW:0] || err_o[0] !== e.err) begin
         errors++;
         $display("FAIL after_hold: got idx=%0d cnt=%0d err=%b want idx=%0d cnt=%0d err=%b",
                  idx_o[0], cnt_o[0], err_o[0], e.index, e.count, e.err);
      end
      ack();
   endtask

   task automatic test_reset_mid();
      int sc[$] = '{3, 9, 1, 9, 0, 2, 2, 8, 7, 5};
      int part[$] = '{60000, 60001, 60002, 60003, 60004};
      int sf[$] = '{5, 6, 7, 1};
      int seen = 0;
      send_frame(part, 5, 0, 0);
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (vld_o[0] !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0 || rdy_o[0] !== 1'b1) begin
         errors++; $display("FAIL reset_mid_frame: got %0d valid cycles rdy=%b want 0 and rdy=1", seen, rdy_o[0]);
      end
      send_frame(sc, 10, 10, 0);
      checks++;
      if ({idx_o[0], val_o[0], cnt_o[0], err_o[0]} !== {4'd3, 16'd9, 5'd10, 1'b0}) begin
         errors++;
         $display("FAIL fresh_after_reset: got idx=%0d val=%0d cnt=%0d err=%b want idx=3 val=9 cnt=10 err=0",
                  idx_o[0], val_o[0], cnt_o[0], err_o[0]);
      end
      ack();
      send_frame(sf, 4, 4, 0);
      out_ready = 1'b1; rst = 1'b1; @(negedge clk); rst = 1'b0; out_ready = 1'b0;
      checks++;
      if ({rdy_o[0], vld_o[0], idx_o[0], val_o[0], cnt_o[0], err_o[0]} !== {1'b1, 1'b0, 26'd0}) begin
         errors++;
         $display("FAIL reset_in_hold: got rdy=%b vld=%b idx=%0d val=%0d cnt=%0d err=%b want rdy=1 rest 0",
                  rdy_o[0], vld_o[0], idx_o[0], val_o[0], cnt_o[0], err_o[0]);
      end
   endtask

   task automatic test_one_class();
      o1_in_valid = 1'b1; o1_in_data = 16'h1234; o1_in_last = 1'b1;
      @(negedge clk);
      o1_in_valid = 1'b0;
      checks++;
      if ({o1_rdy, o1_vld, o1_idx, o1_val, o1_cnt, o1_err} !== {1'b0, 1'b1, 1'b0, 16'h1234, 2'd1, 1'b0}) begin
         errors++;
         $display("FAIL one_class_last: got rdy=%b vld=%b idx=%0d val=%h cnt=%0d err=%b want 0 1 0 1234 1 0",
                  o1_rdy, o1_vld, o1_idx, o1_val, o1_cnt, o1_err);
      end
      o1_out_ready = 1'b1; @(negedge clk); o1_out_ready = 1'b0;
      o1_in_valid = 1'b1; o1_in_data = 16'h00AB; o1_in_last = 1'b0;
      @(negedge clk);
      o1_in_valid = 1'b0;
      checks++;
      if ({o1_vld, o1_val, o1_cnt, o1_err} !== {1'b1, 16'h00AB, 2'd1, 1'b1}) begin
         errors++;
         $display("FAIL one_class_nolast: got vld=%b val=%h cnt=%0d err=%b want 1 00ab 1 1",
                  o1_vld, o1_val, o1_cnt, o1_err);
      end
      o1_out_ready = 1'b1; @(negedge clk); o1_out_ready = 1'b0;
   endtask

   task automatic test_random();
      for (int f = 0; f < 40; f++) begin
         int   sc[$];
         int   last_pos;
         exp_t e [3];
         for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 3))
               0:       sc.push_back($urandom_range(0, 3));
               1:       sc.push_back(32'hFFFF - $urandom_range(0, 2));
               2:       sc.push_back(32'h8000 + $urandom_range(0, 2));
               default: sc.push_back($urandom_range(0, 65535));
            endcase
         end
         last_pos = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, N);
         for (int k = 0; k < 3; k++) e[k] = model(sc, last_pos, N, sgn_cfg[k], tie_cfg[k]);
         send_frame(sc, e[0].count, last_pos, 2);
         for (int k = 0; k < 3; k++) begin
            checks++;
            if ({vld_o[k], idx_o[k], val_o[k], cnt_o[k], err_o[k]} !==
                {1'b1, e[k].index[IW-1:0], e[k].value[DW-1:0], e[k].count[IW:0], e[k].err}) begin
               errors++;
               $display("FAIL random f=%0d k=%0d: got vld=%b idx=%0d val=%h cnt=%0d err=%b want vld=1 idx=%0d val=%h cnt=%0d err=%b",
                        f, k, vld_o[k], idx_o[k], val_o[k], cnt_o[k], err_o[k],
                        e[k].index, e[k].value[DW-1:0], e[k].count, e[k].err);
            end
`ifdef ARGMAX_TOP2_EN
            checks++;
            if (sv_o[k] !== e[k].sec_valid || mar_o[k] !== e[k].margin[DW:0] ||
                (e[k].sec_valid && (sidx_o[k] !== e[k].sec_index[IW-1:0] ||
                                    sval_o[k] !== e[k].sec_value[DW-1:0]))) begin
               errors++;
               $display("FAIL random_top2 f=%0d k=%0d: got sv=%b sidx=%0d sval=%h mar=%0d want sv=%b sidx=%0d sval=%h mar=%0d",
                        f, k, sv_o[k], sidx_o[k], sval_o[k], mar_o[k],
                        e[k].sec_valid, e[k].sec_index, e[k].sec_value[DW-1:0], e[k].margin);
            end
`endif
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
         ack();
      end
   endtask

`ifdef ARGMAX_TOP2_EN
   task automatic test_top2();
      int sc[$] = '{3, 9, 1, 8, 0, 2, 2, 8, 7, 5};
      int one[$] = '{42};
      send_frame(sc, 10, 10, 0);
      checks++;
      if ({idx_o[0], sidx_o[0], sval_o[0], mar_o[0], sv_o[0]} !== {4'd1, 4'd7, 16'd8, 17'd1, 1'b1}) begin
         errors++;
         $display("FAIL top2_ref: got idx=%0d sidx=%0d sval=%0d mar=%0d sv=%b want 1 7 8 1 1",
                  idx_o[0], sidx_o[0], sval_o[0], mar_o[0], sv_o[0]);
      end
      ack();
      send_frame(one, 1, 1, 0);
      checks++;
      if ({sv_o[0], mar_o[0]} !== 18'd0) begin
         errors++; $display("FAIL top2_single: got sv=%b mar=%0d want 0 0", sv_o[0], mar_o[0]);
      end
      ack();
   endtask
`endif

   initial begin
      test_reset();
      test_ref_frame();
      test_signed();
      test_short_frame();
      test_hold();
      test_reset_mid();
      test_one_class();
`ifdef ARGMAX_TOP2_EN
      test_top2();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
